// File: rtl/dds_seq_pkg.sv
// Shared definitions for the DDS profile sequencer: field codes, field widths,
// the parked DDS mode, FSM state encoding and the packed profile record.
package dds_seq_pkg;

  localparam logic [2:0] FLD_MODE      = 3'd0;
  localparam logic [2:0] FLD_FIN_HEX   = 3'd1;
  localparam logic [2:0] FLD_AMP       = 3'd2;
  localparam logic [2:0] FLD_ATT       = 3'd3;
  localparam logic [2:0] FLD_DWELL     = 3'd4;
  localparam logic [2:0] FLD_PRT_WIDTH = 3'd5;
  localparam logic [2:0] FLD_PRT_CYCLE = 3'd6;

  localparam int W_MODE      = 16;
  localparam int W_FIN       = 32;
  localparam int W_AMP       = 15;
  localparam int W_ATT       = 10;
  localparam int W_DWELL     = 32;
  localparam int W_PRT_WIDTH = 32;
  localparam int W_PRT_CYCLE = 32;

  localparam logic [W_MODE-1:0] DDS_MODE_OFF = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DWELL  = 3'd2,
    ST_SYNC   = 3'd3,
    ST_FINISH = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [W_MODE-1:0]      mode;
    logic [W_FIN-1:0]       fin_hex;
    logic [W_AMP-1:0]       amp;
    logic [W_ATT-1:0]       att;
    logic [W_DWELL-1:0]     dwell;
    logic [W_PRT_WIDTH-1:0] prt_width;
    logic [W_PRT_CYCLE-1:0] prt_cycle;
  } dds_prof_t;

endpackage

// File: rtl/dds_profile_ram.sv
// Profile table: DEPTH slots of seven fields. Field-wise write port, registered
// field read port for the config bus, and a combinational whole-profile read
// used by the sequencer when it loads a slot.
module dds_profile_ram
  import dds_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic            clk_user_bufg,
  input  logic            rst_glb_n,
  input  logic            cfg_we,
  input  logic            cfg_re,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [2:0]      cfg_field,
  input  logic [31:0]     cfg_wdata,
  output logic [31:0]     cfg_rdata,
  input  logic [AW-1:0]   rd_idx,
  output dds_prof_t       rd_prof
);

  dds_prof_t   mem [DEPTH];
  logic [31:0] fld_rd;

  // Field write; wide data is truncated to the field width, field 7 is dropped.
  always_ff @(posedge clk_user_bufg or negedge rst_glb_n) begin
    if (!rst_glb_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (cfg_we) begin
      case (cfg_field)
        FLD_MODE:      mem[cfg_addr].mode      <= cfg_wdata[W_MODE-1:0];
        FLD_FIN_HEX:   mem[cfg_addr].fin_hex   <= cfg_wdata[W_FIN-1:0];
        FLD_AMP:       mem[cfg_addr].amp       <= cfg_wdata[W_AMP-1:0];
        FLD_ATT:       mem[cfg_addr].att       <= cfg_wdata[W_ATT-1:0];
        FLD_DWELL:     mem[cfg_addr].dwell     <= cfg_wdata[W_DWELL-1:0];
        FLD_PRT_WIDTH: mem[cfg_addr].prt_width <= cfg_wdata[W_PRT_WIDTH-1:0];
        FLD_PRT_CYCLE: mem[cfg_addr].prt_cycle <= cfg_wdata[W_PRT_CYCLE-1:0];
        default: ;
      endcase
    end
  end

  // Field select for readback, zero-extended to 32 bits.
  always_comb begin
    fld_rd = '0;
    case (cfg_field)
      FLD_MODE:      fld_rd = 32'(mem[cfg_addr].mode);
      FLD_FIN_HEX:   fld_rd = 32'(mem[cfg_addr].fin_hex);
      FLD_AMP:       fld_rd = 32'(mem[cfg_addr].amp);
      FLD_ATT:       fld_rd = 32'(mem[cfg_addr].att);
      FLD_DWELL:     fld_rd = 32'(mem[cfg_addr].dwell);
      FLD_PRT_WIDTH: fld_rd = 32'(mem[cfg_addr].prt_width);
      FLD_PRT_CYCLE: fld_rd = 32'(mem[cfg_addr].prt_cycle);
      default:       fld_rd = '0;
    endcase
  end

  // Registered read; a same-cycle write lands after this sample, so the old value is returned.
  always_ff @(posedge clk_user_bufg or negedge rst_glb_n) begin
    if (!rst_glb_n) cfg_rdata <= '0;
    else if (cfg_re) cfg_rdata <= fld_rd;
  end

  assign rd_prof = mem[rd_idx];

endmodule

// File: rtl/dds_profile_sequencer.sv
// Steps the DDS through the programmed profile table, holding each profile for
// its dwell and optionally deferring switches until the transmit pulse is idle.
//
//   state  | meaning
//   IDLE   | waiting for seq_start; outputs hold last values
//   LOAD   | register profile[idx] onto the DDS outputs, arm dwell timer
//   DWELL  | dwell down-counter running; terminal count picks next step
//   SYNC   | next profile chosen, waiting for pulse_user low
//   FINISH | one-cycle seq_done_o, then IDLE
module dds_profile_sequencer
  import dds_seq_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int AW            = 3,
  parameter bit SYNC_TO_PULSE = 1'b1
) (
  input  logic                   clk_user_bufg,
  input  logic                   rst_glb_n,
  input  logic                   cfg_we,
  input  logic                   cfg_re,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [2:0]             cfg_field,
  input  logic [31:0]            cfg_wdata,
  output logic [31:0]            cfg_rdata,
  input  logic                   seq_start,
  input  logic                   seq_stop,
  input  logic                   loop_en,
  input  logic [AW:0]            num_profiles,
  input  logic                   pulse_user,
  output logic [W_MODE-1:0]      dds_mode_o,
  output logic [W_FIN-1:0]       dds_fin_hex_o,
  output logic [W_AMP-1:0]       dds_amp_multip_o,
  output logic [W_ATT-1:0]       dds_att_0p1dB_o,
  output logic [W_PRT_WIDTH-1:0] dds_prt_width_o,
  output logic [W_PRT_CYCLE-1:0] dds_prt_cycle_o,
  output logic                   upd_stb_o,
  output logic                   busy_o,
  output logic [AW-1:0]          prof_idx_o,
  output logic                   seq_done_o
);

  localparam logic [AW:0]   N_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   N_MAX   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  seq_state_t        state, state_nxt;
  logic [AW-1:0]     idx, idx_next;
  logic [AW:0]       eff_n;
  logic [W_DWELL-1:0] dwell_cnt, dwell_load;
  logic              dwell_exp, last_prof, seq_end;
  dds_prof_t         rd_prof;

  // Profile count clamped to 1..DEPTH.
  function automatic logic [AW:0] clamp_n(input logic [AW:0] n);
    if (n == '0)        return N_ONE;
    else if (n > N_MAX) return N_MAX;
    else                return n;
  endfunction

  dds_profile_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_user_bufg (clk_user_bufg),
    .rst_glb_n     (rst_glb_n),
    .cfg_we        (cfg_we),
    .cfg_re        (cfg_re),
    .cfg_addr      (cfg_addr),
    .cfg_field     (cfg_field),
    .cfg_wdata     (cfg_wdata),
    .cfg_rdata     (cfg_rdata),
    .rd_idx        (idx),
    .rd_prof       (rd_prof)
  );

  // A zero dwell behaves as one so every profile is visible for at least two cycles.
  assign dwell_load = (rd_prof.dwell == '0) ? '0 : rd_prof.dwell - 32'd1;
  assign dwell_exp  = (dwell_cnt == '0);
  assign last_prof  = ({1'b0, idx} == eff_n - N_ONE);
  assign idx_next   = last_prof ? '0 : idx + IDX_ONE;
  assign seq_end    = last_prof && !loop_en;

  assign busy_o     = (state != ST_IDLE);
  assign seq_done_o = (state == ST_FINISH);

  // State register.
  always_ff @(posedge clk_user_bufg or negedge rst_glb_n) begin
    if (!rst_glb_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; stop overrides everything, including a coincident start.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (seq_start) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_DWELL;
      ST_DWELL: begin
        if (dwell_exp) begin
          if (seq_end)            state_nxt = ST_FINISH;
          else if (SYNC_TO_PULSE) state_nxt = ST_SYNC;
          else                    state_nxt = ST_LOAD;
        end
      end
      ST_SYNC:   if (!pulse_user) state_nxt = ST_LOAD;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (seq_stop) state_nxt = ST_IDLE;
  end

  // Index, dwell timer and DDS output registers.
  always_ff @(posedge clk_user_bufg or negedge rst_glb_n) begin
    if (!rst_glb_n) begin
      idx              <= '0;
      eff_n            <= N_ONE;
      dwell_cnt        <= '0;
      upd_stb_o        <= 1'b0;
      prof_idx_o       <= '0;
      dds_mode_o       <= '0;
      dds_fin_hex_o    <= '0;
      dds_amp_multip_o <= '0;
      dds_att_0p1dB_o  <= '0;
      dds_prt_width_o  <= '0;
      dds_prt_cycle_o  <= '0;
    end else begin
      upd_stb_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (seq_start && !seq_stop) begin
            idx   <= '0;
            eff_n <= clamp_n(num_profiles);
          end
        end
        ST_LOAD: begin
          if (!seq_stop) begin
            dds_mode_o       <= rd_prof.mode;
            dds_fin_hex_o    <= rd_prof.fin_hex;
            dds_amp_multip_o <= rd_prof.amp;
            dds_att_0p1dB_o  <= rd_prof.att;
            dds_prt_width_o  <= rd_prof.prt_width;
            dds_prt_cycle_o  <= rd_prof.prt_cycle;
            prof_idx_o       <= idx;
            dwell_cnt        <= dwell_load;
            upd_stb_o        <= 1'b1;
          end
        end
        ST_DWELL: begin
          if (!dwell_exp)    dwell_cnt <= dwell_cnt - 32'd1;
          else if (!seq_end) idx <= idx_next;
        end
        default: ;
      endcase
      if (seq_stop && state != ST_IDLE) begin
        dds_mode_o       <= DDS_MODE_OFF;
        dds_amp_multip_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dds_profile_sequencer.sv
// Directed bench for dds_profile_sequencer. Instance dut runs with immediate
// switching, dut_s with pulse-synchronised switching; both share the config bus.
module tb_dds_profile_sequencer;
  import dds_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, cfg_re;
  logic [2:0]  cfg_addr, cfg_field;
  logic [31:0] cfg_wdata;
  logic        seq_start, seq_stop, seq_start_s, seq_stop_s;
  logic        loop_en, pulse_user;
  logic [3:0]  num_profiles;

  logic [31:0] cfg_rdata, cfg_rdata_s;
  logic [15:0] mode, mode_s;
  logic [31:0] fin, fin_s;
  logic [14:0] amp, amp_s;
  logic [9:0]  att, att_s;
  logic [31:0] pw, pw_s, pc, pc_s;
  logic        upd, upd_s, busy, busy_s, done, done_s;
  logic [2:0]  pidx, pidx_s;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0;
  int upd_q[$], idx_q[$], done_q[$], upd_s_q[$], done_s_q[$];
  logic [31:0] rd_val;

  always #5 clk = ~clk;

  dds_profile_sequencer #(.DEPTH(8), .AW(3), .SYNC_TO_PULSE(1'b0)) dut (
    .clk_user_bufg(clk), .rst_glb_n(rst_n),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_field(cfg_field),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .seq_start(seq_start), .seq_stop(seq_stop), .loop_en(loop_en),
    .num_profiles(num_profiles), .pulse_user(pulse_user),
    .dds_mode_o(mode), .dds_fin_hex_o(fin), .dds_amp_multip_o(amp),
    .dds_att_0p1dB_o(att), .dds_prt_width_o(pw), .dds_prt_cycle_o(pc),
    .upd_stb_o(upd), .busy_o(busy), .prof_idx_o(pidx), .seq_done_o(done)
  );

  dds_profile_sequencer #(.DEPTH(8), .AW(3), .SYNC_TO_PULSE(1'b1)) dut_s (
    .clk_user_bufg(clk), .rst_glb_n(rst_n),
    .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_field(cfg_field),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata_s),
    .seq_start(seq_start_s), .seq_stop(seq_stop_s), .loop_en(loop_en),
    .num_profiles(num_profiles), .pulse_user(pulse_user),
    .dds_mode_o(mode_s), .dds_fin_hex_o(fin_s), .dds_amp_multip_o(amp_s),
    .dds_att_0p1dB_o(att_s), .dds_prt_width_o(pw_s), .dds_prt_cycle_o(pc_s),
    .upd_stb_o(upd_s), .busy_o(busy_s), .prof_idx_o(pidx_s), .seq_done_o(done_s)
  );

  // Cycle number of the current clock period.
  always @(posedge clk) cyc <= cyc + 1;

  // Event log of strobes, time-stamped by cycle.
  always @(negedge clk) begin
    if (upd) begin upd_q.push_back(cyc); idx_q.push_back(int'(pidx)); end
    if (done) done_q.push_back(cyc);
    if (upd_s) upd_s_q.push_back(cyc);
    if (done_s) done_s_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [2:0] f, input logic [31:0] d);
    cfg_addr = 3'(a); cfg_field = f; cfg_wdata = d; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic rd(input int a, input logic [2:0] f, output logic [31:0] d);
    cfg_addr = 3'(a); cfg_field = f; cfg_re = 1'b1;
    @(negedge clk);
    cfg_re = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic start_seq(output int t);
    t = cyc; seq_start = 1'b1;
    @(negedge clk);
    seq_start = 1'b0;
  endtask

  task automatic clear_logs();
    upd_q.delete(); idx_q.delete(); done_q.delete(); upd_s_q.delete(); done_s_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dw[3];
    dw = '{4, 0, 10};
    rst_n = 1'b0; cfg_we = 0; cfg_re = 0; cfg_addr = 0; cfg_field = 0; cfg_wdata = 0;
    seq_start = 0; seq_stop = 0; seq_start_s = 0; seq_stop_s = 0;
    loop_en = 0; pulse_user = 0; num_profiles = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_fin", fin, 0);
    chk("rst_amp", 32'(amp), 0);
    chk("rst_upd", 32'(upd), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_idx", 32'(pidx), 0);
    chk("rst_rdata", cfg_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      wr(i, FLD_MODE, 32'(i + 1));
      wr(i, FLD_FIN_HEX, 32'(i + 1) << 28);
      wr(i, FLD_AMP, 32'(i + 1) << 8);
      wr(i, FLD_ATT, 32'(i + 5));
      wr(i, FLD_DWELL, 32'(dw[i]));
      wr(i, FLD_PRT_WIDTH, 32'(10 * (i + 1)));
      wr(i, FLD_PRT_CYCLE, 32'(100 * (i + 1)));
    end

    // Three-profile run, plus a start while busy that must be ignored.
    clear_logs();
    num_profiles = 4'd3; loop_en = 0;
    start_seq(t0);
    chk("t1_busy_load", 32'(busy), 1);
    goto(t0 + 5); seq_start = 1'b1; @(negedge clk); seq_start = 1'b0;
    goto(t0 + 19);
    chk("t1_busy_fin", 32'(busy), 1);
    goto(t0 + 20);
    chk("t1_busy_end", 32'(busy), 0);
    goto(t0 + 24);
    chk("t1_nupd", upd_q.size(), 3);
    chk("t1_upd0", qat(upd_q, 0) - t0, 2);
    chk("t1_upd1", qat(upd_q, 1) - t0, 7);
    chk("t1_upd2", qat(upd_q, 2) - t0, 9);
    chk("t1_idx1", qat(idx_q, 1), 1);
    chk("t1_idx2", qat(idx_q, 2), 2);
    chk("t1_ndone", done_q.size(), 1);
    chk("t1_done", qat(done_q, 0) - t0, 19);
    chk("t1_mode", 32'(mode), 3);
    chk("t1_fin", fin, 32'h3000_0000);
    chk("t1_amp", 32'(amp), 32'h300);
    chk("t1_att", 32'(att), 7);
    chk("t1_pw", pw, 30);
    chk("t1_pc", pc, 300);
    chk("t1_pidx", 32'(pidx), 2);

    // Loop wrap, loop_en cleared during the second pass of profile 0.
    clear_logs();
    num_profiles = 4'd2; loop_en = 1'b1;
    start_seq(t0);
    goto(t0 + 10); loop_en = 1'b0;
    goto(t0 + 20);
    chk("lp_nupd", upd_q.size(), 4);
    chk("lp_upd2", qat(upd_q, 2) - t0, 9);
    chk("lp_upd3", qat(upd_q, 3) - t0, 14);
    chk("lp_idx0", qat(idx_q, 0), 0);
    chk("lp_idx1", qat(idx_q, 1), 1);
    chk("lp_idx2", qat(idx_q, 2), 0);
    chk("lp_idx3", qat(idx_q, 3), 1);
    chk("lp_done", qat(done_q, 0) - t0, 15);

    // Pulse-synchronised switching on dut_s.
    clear_logs();
    pulse_user = 1'b1;
    t0 = cyc; seq_start_s = 1'b1; @(negedge clk); seq_start_s = 1'b0;
    goto(t0 + 15);
    chk("sy_busy", 32'(busy_s), 1);
    chk("sy_nupd_hold", upd_s_q.size(), 1);
    chk("sy_pidx_hold", 32'(pidx_s), 0);
    goto(t0 + 20); pulse_user = 1'b0;
    goto(t0 + 26);
    chk("sy_nupd", upd_s_q.size(), 2);
    chk("sy_upd1", qat(upd_s_q, 1) - t0, 22);
    chk("sy_done", qat(done_s_q, 0) - t0, 23);
    chk("sy_pidx", 32'(pidx_s), 1);

    // Abort mid-dwell, then a simultaneous start+stop from idle.
    clear_logs();
    num_profiles = 4'd3;
    start_seq(t0);
    goto(t0 + 4); seq_stop = 1'b1; @(negedge clk); seq_stop = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_mode", 32'(mode), 0);
    chk("ab_amp", 32'(amp), 0);
    chk("ab_fin_hold", fin, 32'h1000_0000);
    chk("ab_att_hold", 32'(att), 5);
    goto(t0 + 25);
    chk("ab_ndone", done_q.size(), 0);
    chk("ab_nupd", upd_q.size(), 1);
    seq_start = 1'b1; seq_stop = 1'b1; @(negedge clk); seq_start = 1'b0; seq_stop = 1'b0;
    chk("ss_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    chk("ss_busy_late", 32'(busy), 0);
    chk("ss_nupd", upd_q.size(), 1);

    // Profile count clamping.
    clear_logs();
    num_profiles = 4'd0;
    start_seq(t0);
    goto(t0 + 12);
    chk("c0_nupd", upd_q.size(), 1);
    chk("c0_done", qat(done_q, 0) - t0, 6);
    clear_logs();
    num_profiles = 4'd15;
    start_seq(t0);
    goto(t0 + 35);
    chk("c15_nupd", upd_q.size(), 8);
    chk("c15_idx7", qat(idx_q, 7), 7);
    chk("c15_upd7", qat(upd_q, 7) - t0, 28);
    chk("c15_done", qat(done_q, 0) - t0, 29);

    // Readback: truncation, reserved field, write/read collision.
    wr(5, FLD_AMP, 32'h0001_2345);
    rd(5, FLD_AMP, rd_val);
    chk("rb_amp", rd_val, 32'h2345);
    wr(5, 3'd7, 32'hFFFF_FFFF);
    rd(5, 3'd7, rd_val);
    chk("rb_fld7", rd_val, 0);
    rd(2, FLD_FIN_HEX, rd_val);
    chk("rb_fin2", rd_val, 32'h3000_0000);
    cfg_addr = 3'd5; cfg_field = FLD_AMP; cfg_wdata = 32'h7; cfg_we = 1'b1; cfg_re = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; cfg_re = 1'b0;
    chk("rb_coll_old", cfg_rdata, 32'h2345);
    rd(5, FLD_AMP, rd_val);
    chk("rb_coll_new", rd_val, 32'h7);

    // Asynchronous reset mid-dwell.
    clear_logs();
    num_profiles = 4'd3;
    start_seq(t0);
    goto(t0 + 4);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_mode", 32'(mode), 0);
    chk("ar_fin", fin, 0);
    chk("ar_amp", 32'(amp), 0);
    chk("ar_pw", pw, 0);
    chk("ar_rdata", cfg_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(0, FLD_FIN_HEX, rd_val);
    chk("ar_tbl_fin0", rd_val, 0);
    rd(2, FLD_DWELL, rd_val);
    chk("ar_tbl_dw2", rd_val, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
